// File: rtl/reg_file_bus.sv
// Register file with a tri-state bus read port (A), an always-driven ALU read port (B), one write port and a clear sweeper.
// Reads are combinational with optional write bypass, writes land next cycle, and writes are dropped while a sweep runs.
module reg_file_bus #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 8,
  parameter int               ADDR_W      = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(16'haa55),
  parameter int               BYPASS      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_from_bus,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              read,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WIDTH-1:0]  out_to_bus,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_out,
  input  logic              clear,
  output logic              busy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic [WIDTH-1:0]  regs [NUM_REGS];
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              wr_ok;
  logic [WIDTH-1:0]  a_dat;
  logic [WIDTH-1:0]  b_dat;

  assign wr_ok = write && !busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      // Writes and sweep stores never coincide: the sweep only runs while busy gates writes off.
      if (wr_ok) regs[write_addr] <= in_from_bus;
      case (state)
        IDLE: begin
          if (clear) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          regs[cnt] <= RESET_VALUE;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    a_dat = regs[read_addr];
    b_dat = regs[b_addr];
    if (BYPASS != 0 && wr_ok && write_addr == read_addr) a_dat = in_from_bus;
    if (BYPASS != 0 && wr_ok && write_addr == b_addr)    b_dat = in_from_bus;
  end

  assign out_to_bus = read ? a_dat : {WIDTH{1'bz}};
  assign b_out      = b_dat;

endmodule

// File: doc/reg_file_bus.md
Name: reg_file_bus

Overview:
- Parametrised multi-register file for the simple-CPU datapath. It generalises the single bus-attached register to NUM_REGS addressable registers.
- Port A is a shared-bus read port with tri-state drive. Port B is an always-driven read port feeding the ALU. There is one synchronous write port.
- A built-in clear sequencer re-initialises every register to its reset value, one register per cycle, without asserting reset.

Parameters:
- WIDTH, 16, data width of every register and bus.
- NUM_REGS, 8, number of registers; power of two, 2 to 256.
- ADDR_W, 3, address width; must equal log2(NUM_REGS).
- RESET_VALUE, 16'haa55, value loaded into every register by reset or by a clear sweep; zero-extended or truncated to WIDTH.
- BYPASS, 1, 1 = same-cycle write data forwarded to both read ports on an address match; 0 = reads return the stored value.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_from_bus  input  WIDTH  write data.
- write  input  1  write enable.
- write_addr  input  ADDR_W  register to write.
- read  input  1  port A bus-drive enable.
- read_addr  input  ADDR_W  port A register select.
- out_to_bus  output  WIDTH  port A data; high-impedance when not driving.
- b_addr  input  ADDR_W  port B register select.
- b_out  output  WIDTH  port B data; always driven.
- clear  input  1  one-cycle pulse that starts a clear sweep.
- busy  output  1  high while a clear sweep runs.

Behaviour:
- Reset:
  - reset=0 at a rising edge loads all registers with RESET_VALUE.
  - The FSM goes to IDLE, the sweep counter goes to 0 and busy goes to 0.
  - Reset overrides write and clear in the same cycle.
  - Reset asserted mid-sweep aborts the sweep; every register still ends at RESET_VALUE.
- Write:
  - When write=1 and busy=0 at a rising edge, register[write_addr] <= in_from_bus.
  - Latency is one cycle: the stored value is visible on the read ports in the next cycle.
  - When busy=1, write is ignored and dropped, not queued.
- Port A:
  - out_to_bus = read ? data(read_addr) : all-Z. Combinational.
  - read may be asserted during busy; it returns the current contents, partially cleared.
- Port B:
  - b_out = data(b_addr). Combinational; never Z.
- data(a), BYPASS=1:
  - If write=1, busy=0 and write_addr==a, data(a) = in_from_bus.
  - Otherwise data(a) = register[a].
- data(a), BYPASS=0:
  - data(a) = register[a] always.
- Clear FSM, states IDLE and SWEEP, counter cnt[ADDR_W-1:0]:
  - IDLE: clear=1 moves to SWEEP with cnt=0 and busy=1 from the next cycle. A write in the same cycle as the clear pulse is still performed.
  - SWEEP: each cycle, register[cnt] <= RESET_VALUE and cnt increments.
  - SWEEP exit: when cnt==NUM_REGS-1, that register is cleared and the FSM returns to IDLE, with busy=0 in the next cycle.
  - Sweep length: busy is high for exactly NUM_REGS cycles.
  - clear asserted during SWEEP is ignored; the sweep does not restart.
  - The counter does not wrap past NUM_REGS-1.
- Out-of-range addresses: none are possible, because NUM_REGS = 2^ADDR_W.

Test Plan:
- Reset and power-on values: hold reset=0 for 2 cycles, then release. Read every address on both ports; expect 16'haa55 on each. With read=0, out_to_bus is Z.
- Write then read: write 16'h1234 to reg 3, then 16'hbeef to reg 7. Next cycle set read=1, read_addr=3 and b_addr=7; expect out_to_bus=16'h1234 and b_out=16'hbeef. Reg 0 is still 16'haa55.
- Bypass: with BYPASS=1, write 16'h5a5a to reg 2 with read_addr=2 and b_addr=2 in the same cycle; both ports show 16'h5a5a in that cycle. With BYPASS=0, both ports show the old value 16'haa55.
- Clear sweep:
  - Setup: fill regs with 16'h0001..16'h0008, then pulse clear.
  - busy is high for exactly 8 cycles.
  - Midway, reg k already swept reads 16'haa55 while higher regs keep their data.
  - A write to reg 6 during busy is dropped; after the sweep, all regs read 16'haa55.
  - A second clear pulse mid-sweep does not extend busy.
- Reset mid-sweep: start a sweep, then assert reset=0 on cycle 3. Next cycle busy=0 and all regs read 16'haa55. A write afterwards succeeds.
- Write/reset/clear collision: write=1 with reset=0 gives no write. write=1 with a clear pulse in IDLE performs the write, and the register is later overwritten by the sweep.
